// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduler: FSM states, LFSR setup,
// sprite type codes and coordinate width.
package obstacle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StSpawn
  } state_e;

  typedef enum logic [1:0] {
    ObsCactus = 2'd0,
    ObsPole   = 2'd1,
    ObsSpike  = 2'd2
  } obs_type_e;

  localparam int unsigned CoordW = 10;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Polynomial taps 16,14,13,11 expressed as state bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Fold the unused code 3 back onto cactus.
  function automatic logic [1:0] type_from_lfsr(logic [1:0] r);
    return (r == 2'd3) ? 2'(ObsCactus) : r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left every clock, feedback into bit 0.
module lfsr16
  import obstacle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LfsrSeed;
    end else begin
      state_q <= {state_q[14:0], ^(state_q & LfsrTaps)};
    end
  end

  assign state = state_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle pool controller: on each enabled vsync falling edge it scrolls every
// live slot left by the current speed, retires slots off the left edge, then may spawn one.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SPRITE_H        = 32,
  parameter int unsigned GROUND_Y        = 400,
  parameter int unsigned SPAWN_MIN       = 40,
  parameter int unsigned SPEED_INIT      = 2,
  parameter int unsigned SPEED_MAX       = 8,
  parameter int unsigned SPEED_UP_FRAMES = 600
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vsync,
  input  logic                        enable,
  input  logic                        halt,
  output logic [NUM_SLOTS*CoordW-1:0] obs_x,
  output logic [NUM_SLOTS*CoordW-1:0] obs_y,
  output logic [NUM_SLOTS*2-1:0]      obs_type,
  output logic [NUM_SLOTS-1:0]        obs_active,
  output logic [3:0]                  speed,
  output logic                        busy,
  output logic                        spawned
);

  localparam int unsigned IdxW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CoordW-1:0] ParkX  = CoordW'(SCREEN_W);
  localparam logic [CoordW-1:0] SpawnY = CoordW'(GROUND_Y - SPRITE_H);

  logic [15:0] lfsr;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:8];

  // vs_q[1] is the synchronized vsync, vs_q[2] its previous value.
  logic [2:0] vs_q;
  logic       tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= {vs_q[1:0], vsync};
      tick_q <= vs_q[2] & ~vs_q[1];
    end
  end

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CoordW-1:0]    x_q [NUM_SLOTS];
  logic [CoordW-1:0]    x_d [NUM_SLOTS];
  logic [1:0]           type_q [NUM_SLOTS];
  logic [1:0]           type_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [3:0]           speed_q, speed_d;
  logic [6:0]           spawn_cnt_q, spawn_cnt_d;
  logic [9:0]           frame_cnt_q, frame_cnt_d;
  logic                 spawned_q, spawned_d;
  logic                 busy_q;

  logic                 run;
  logic                 free_found;
  logic [IdxW-1:0]      free_idx;
  logic [CoordW-1:0]    speed_ext;

  assign run       = enable & ~halt;
  assign speed_ext = {{(CoordW-4){1'b0}}, speed_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    type_d      = type_q;
    active_d    = active_q;
    speed_d     = speed_q;
    spawn_cnt_d = spawn_cnt_q;
    frame_cnt_d = frame_cnt_q;
    spawned_d   = 1'b0;
    free_found  = 1'b0;
    free_idx    = '0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end

    if (run) begin
      unique case (state_q)
        StIdle: begin
          if (tick_q) begin
            state_d = StMove;
            idx_d   = '0;
          end
        end
        StMove: begin
          if (active_q[idx_q]) begin
            if (x_q[idx_q] >= speed_ext) begin
              x_d[idx_q] = x_q[idx_q] - speed_ext;
            end else begin
              active_d[idx_q] = 1'b0;
              x_d[idx_q]      = ParkX;
            end
          end
          if (idx_q == IdxW'(NUM_SLOTS - 1)) begin
            state_d = StSpawn;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StSpawn: begin
          if (frame_cnt_q == 10'(SPEED_UP_FRAMES - 1)) begin
            frame_cnt_d = '0;
            if (speed_q < 4'(SPEED_MAX)) begin
              speed_d = speed_q + 4'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 10'd1;
          end
          if (spawn_cnt_q != '0) begin
            spawn_cnt_d = spawn_cnt_q - 7'd1;
          end else if (free_found) begin
            x_d[free_idx]      = ParkX;
            type_d[free_idx]   = type_from_lfsr(lfsr[1:0]);
            active_d[free_idx] = 1'b1;
            spawned_d          = 1'b1;
            spawn_cnt_d        = 7'(SPAWN_MIN) + {1'b0, lfsr[7:2]};
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      x_q         <= '{default: ParkX};
      type_q      <= '{default: ObsCactus};
      active_q    <= '0;
      speed_q     <= 4'(SPEED_INIT);
      spawn_cnt_q <= 7'(SPAWN_MIN);
      frame_cnt_q <= '0;
      spawned_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      type_q      <= type_d;
      active_q    <= active_d;
      speed_q     <= speed_d;
      spawn_cnt_q <= spawn_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      spawned_q   <= spawned_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  always_comb begin
    obs_x    = '0;
    obs_y    = '0;
    obs_type = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      obs_x[i*CoordW +: CoordW] = x_q[i];
      obs_y[i*CoordW +: CoordW] = SpawnY;
      obs_type[i*2 +: 2]        = type_q[i];
    end
  end

  assign obs_active = active_q;
  assign speed      = speed_q;
  assign busy       = busy_q;
  assign spawned    = spawned_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with a frame-level behavioural model of the pool.
module tb_obstacle_scheduler;

  localparam int NS     = 4;
  localparam int PERIOD = 16;

  logic          clk;
  logic          reset;
  logic          vsync;
  logic          enable;
  logic          halt;
  logic [NS*10-1:0] obs_x;
  logic [NS*10-1:0] obs_y;
  logic [NS*2-1:0]  obs_type;
  logic [NS-1:0]    obs_active;
  logic [3:0]       speed;
  logic             busy;
  logic             spawned;

  obstacle_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .enable     (enable),
    .halt       (halt),
    .obs_x      (obs_x),
    .obs_y      (obs_y),
    .obs_type   (obs_type),
    .obs_active (obs_active),
    .speed      (speed),
    .busy       (busy),
    .spawned    (spawned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference random source: the spec's 16-bit LFSR, seeded on reset.
  logic [15:0] mlfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) mlfsr <= 16'hACE1;
    else mlfsr <= {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  end

  int n_cmp = 0;
  int n_bad = 0;
  int frame_no = 0;

  // Pool model
  int m_x[NS];
  int m_act[NS];
  int m_type[NS];
  int m_speed;
  int m_spawn_cnt;
  int m_frames;
  int m_spawned;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (frame %0d): got %0h expected %0h", name, frame_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_x[s] = 640; m_act[s] = 0; m_type[s] = 0;
    end
    m_speed = 2; m_spawn_cnt = 40; m_frames = 0; m_spawned = 0;
  endtask

  task automatic model_frame(input logic [15:0] r);
    int free;
    m_spawned = 0;
    for (int s = 0; s < NS; s++) begin
      if (m_act[s] != 0) begin
        if (m_x[s] >= m_speed) m_x[s] = m_x[s] - m_speed;
        else begin m_act[s] = 0; m_x[s] = 640; end
      end
    end
    m_frames++;
    if (m_frames == 600) begin
      m_frames = 0;
      if (m_speed < 8) m_speed++;
    end
    if (m_spawn_cnt > 0) m_spawn_cnt--;
    else begin
      free = -1;
      for (int s = NS - 1; s >= 0; s--) if (m_act[s] == 0) free = s;
      if (free >= 0) begin
        m_x[free] = 640;
        m_act[free] = 1;
        m_type[free] = (int'(r % 4) == 3) ? 0 : int'(r % 4);
        m_spawn_cnt = 40 + int'((r / 4) % 64);
        m_spawned = 1;
      end
    end
  endtask

  task automatic compare_model();
    logic [NS*10-1:0] ex, ey;
    logic [NS*2-1:0]  et;
    logic [NS-1:0]    ea;
    for (int s = 0; s < NS; s++) begin
      ex[s*10 +: 10] = 10'(m_x[s]);
      ey[s*10 +: 10] = 10'd368;
      et[s*2 +: 2]   = 2'(m_type[s]);
      ea[s]          = (m_act[s] != 0);
    end
    chk("obs_x", 64'(obs_x), 64'(ex));
    chk("obs_y", 64'(obs_y), 64'(ey));
    chk("obs_type", 64'(obs_type), 64'(et));
    chk("obs_active", 64'(obs_active), 64'(ea));
    chk("speed", 64'(speed), 64'(m_speed));
  endtask

  // One video frame: vsync low for 4 cycles, high for the rest.
  task automatic run_frame(output int spawn_n);
    logic [15:0] snap;
    int busy_n;
    bit live;
    live = enable && !halt;
    busy_n = 0; spawn_n = 0; snap = '0;
    @(negedge clk); vsync = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      @(posedge clk); #1;
      if (i == 7) snap = mlfsr;  // LFSR value during the SPAWN cycle
      if (i == 4) vsync = 1'b1;
      busy_n += int'(busy);
      spawn_n += int'(spawned);
    end
    frame_no++;
    if (live) model_frame(snap);
    chk("busy_cycles", 64'(busy_n), live ? 64'd5 : 64'd0);
    chk("spawned_pulses", 64'(spawn_n), 64'(m_spawned));
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, 64'(obs_x), 64'({4{10'd640}}));
    chk({tag, "_y"}, 64'(obs_y), 64'({4{10'd368}}));
    chk({tag, "_type"}, 64'(obs_type), 64'd0);
    chk({tag, "_active"}, 64'(obs_active), 64'd0);
    chk({tag, "_speed"}, 64'(speed), 64'd2);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_spawned"}, 64'(spawned), 64'd0);
  endtask

  int sp;
  int first_spawn;
  logic [NS*10-1:0] hold_x;
  logic [NS*2-1:0]  hold_t;
  logic [NS-1:0]    hold_a;

  initial begin
    reset = 1'b0; enable = 1'b0; halt = 1'b0; vsync = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // Ticks with the game stopped must not move anything.
    repeat (2) run_frame(sp);

    enable = 1'b1;
    first_spawn = 0;
    for (int f = 1; f <= 60; f++) begin
      run_frame(sp);
      if (sp != 0 && first_spawn == 0) first_spawn = f;
      if (f == 41) begin
        chk("first_x", 64'(obs_x[9:0]), 64'd640);
        chk("first_y", 64'(obs_y[9:0]), 64'd368);
        chk("first_type_range", 64'(obs_type[1:0] <= 2'd2), 64'd1);
        chk("first_active", 64'(obs_active), 64'b0001);
      end
      if (f == 51) chk("scroll_10_frames", 64'(obs_x[9:0]), 64'd620);
    end
    chk("first_spawn_frame", 64'(first_spawn), 64'd41);

    // Halt freezes everything.
    halt = 1'b1;
    hold_x = obs_x; hold_t = obs_type; hold_a = obs_active;
    repeat (5) begin
      run_frame(sp);
      chk("halt_x", 64'(obs_x), 64'(hold_x));
      chk("halt_type", 64'(obs_type), 64'(hold_t));
      chk("halt_active", 64'(obs_active), 64'(hold_a));
    end
    halt = 1'b0;

    // Reset during the MOVE step of slot 1.
    @(negedge clk); vsync = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 4) vsync = 1'b1;
    end
    chk("busy_mid_update", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (PERIOD) @(negedge clk);

    // Long run: speed ramps every 600 frames and saturates at 8.
    for (int f = 1; f <= 3700; f++) begin
      run_frame(sp);
      if (f == 599) chk("speed_before_ramp", 64'(speed), 64'd2);
      if (f == 600) chk("speed_first_ramp", 64'(speed), 64'd3);
      if (f == 3600) chk("speed_saturated", 64'(speed), 64'd8);
    end
    chk("speed_held_max", 64'(speed), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Per-frame controller for the obstacle sprites: owns a fixed pool of obstacle slots, spawns obstacles at pseudo-random intervals, scrolls them left by a frame-rate speed that ramps over time, and retires them off the left edge. It sits between game logic and the obstacle sprite renderers. It drives each renderer's `sprite_x`/`sprite_y` plus a sprite-type select, and updates only during vertical blanking.

## Interface
- `NUM_SLOTS`, 4: number of obstacle slots/renderers.
- `SCREEN_W`, 640: spawn x coordinate; parked x of inactive slots.
- `SPRITE_H`, 32: obstacle sprite height.
- `GROUND_Y`, 400: ground line; obstacle y = `GROUND_Y - SPRITE_H`.
- `SPAWN_MIN`, 40: minimum frames between spawns.
- `SPEED_INIT`, 2: pixels/frame after reset.
- `SPEED_MAX`, 8: speed ceiling.
- `SPEED_UP_FRAMES`, 600: frames between speed increments.

Ports:
- `clk` in 1: pixel clock, single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `vsync` in 1: raw vsync from the video timing generator.
- `enable` in 1: game running; frame updates occur only when high.
- `halt` in 1: freeze after collision; no move, spawn or speed change.
- `obs_x` out `NUM_SLOTS*10`: slot i x at bits `[10i+9:10i]`.
- `obs_y` out `NUM_SLOTS*10`: slot i y.
- `obs_type` out `NUM_SLOTS*2`: sprite select per slot, values 0–2.
- `obs_active` out `NUM_SLOTS`: slot holds a live obstacle.
- `speed` out 4: current pixels/frame.
- `busy` out 1: high while the update FSM is not in IDLE.
- `spawned` out 1: one-cycle pulse when a slot is filled.

## Operation
- **vsync edge detection:** `vsync` passes through a 2-flop synchronizer. A falling edge of the synchronized signal produces `frame_tick`, one cycle wide.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, seed `16'hACE1`. Advances every clock, including while halted. Never reaches zero.

FSM states and transitions:
- **IDLE:**
  - → MOVE on `frame_tick & enable & ~halt`.
  - Otherwise stays in IDLE.
  - A `frame_tick` while not in IDLE is ignored.
- **MOVE:** processes one slot per cycle, index 0..`NUM_SLOTS-1`.
  - Active slot, `x >= speed`: `x ← x - speed`.
  - Active slot, `x < speed`: `active ← 0`, `x ← SCREEN_W`.
  - Inactive slot: unchanged.
  - After the last slot → SPAWN.
- **SPAWN:** one cycle.
  - Frame counter: increments. When it reaches `SPEED_UP_FRAMES` it wraps to 0, and `speed` increments, saturating at `SPEED_MAX`.
  - Spawn counter, nonzero: decrements.
  - Spawn counter zero, a free slot exists: fill the lowest-index free slot.
    - Slot values: `x=SCREEN_W`, `y=GROUND_Y-SPRITE_H`, `type = (lfsr[1:0]==3) ? 0 : lfsr[1:0]`, `active=1`.
    - Pulse `spawned`.
    - Reload spawn counter with `SPAWN_MIN + lfsr[7:2]`.
  - Spawn counter zero, all slots active: counter stays 0; the spawn retries next frame.
  - → IDLE.
- **Arithmetic:** 10-bit unsigned; subtraction is guarded by the `x >= speed` compare, so no wrap. Spawn counter is 7 bits; frame counter is 10 bits.
- **`halt` or `enable` low:** all state frozen; outputs hold.
- **Reset (asynchronous, also mid-MOVE/SPAWN):** everything returns to its reset value immediately.

Reset values:
- `obs_x` = `SCREEN_W`; `obs_y` = `GROUND_Y-SPRITE_H`; `obs_type` = 0; `obs_active` = 0.
- `speed` = `SPEED_INIT`; `busy` = 0; `spawned` = 0.
- Spawn counter = `SPAWN_MIN`; frame counter = 0; FSM in IDLE; LFSR = seed.

## Timing
- `frame_tick` fires 3 clocks after the raw `vsync` falling edge (2 synchronizer flops + edge register).
- Update occupies `NUM_SLOTS+1` cycles (5 at default) after `frame_tick`, well inside vblank.
- `busy` is high for exactly those cycles.
- All outputs are registered. A slot's outputs change in the cycle after its MOVE/SPAWN step.
- Renderers latch position on vsync falling edge, before this update completes. Displayed positions therefore lag the scheduler by one frame; this is the intended behaviour.
- `spawned` is asserted in the cycle after SPAWN.

## Structure
- Package `obstacle_pkg`:
  - FSM state enum (IDLE, MOVE, SPAWN).
  - LFSR seed and tap constants.
  - Obstacle type codes (0 cactus, 1 pole, 2 spike).
  - Coordinate width constant (10).
- Sub-module `lfsr16` (clk, reset, 16-bit state out). The remainder stays in `obstacle_scheduler`.

## Test plan
- **Reset:** assert `reset=0` mid-simulation, release, `enable=1`. Expect all `obs_active=0`, `obs_x=640`, `speed=2`. The first `spawned` pulse occurs on frame 41; slot 0 then reads x=640, y=368, type in 0–2.
- **Scroll:** single active obstacle at x=640, speed 2, 10 frames. Expect x=620, with `busy` high exactly 5 cycles per frame.
- **Retire:** active slot at x=1, speed 2, one frame. Expect `active=0` and x=640. A slot at x=2 instead ends at x=0 and stays active.
- **Full pool:** all 4 slots active, spawn counter 0, one frame. Expect no `spawned` pulse and counter held at 0. Slot 2 retires in a later frame; expect slot 2 filled in that same frame's SPAWN.
- **Halt and speed ramp:**
  - `halt=1` for 5 frames: all outputs unchanged.
  - 600 enabled frames: `speed` 2→3.
  - 3600+ frames: `speed` saturates at 8.
- **Reset mid-update:** `reset=0` during the MOVE cycle of slot 1. Expect immediate return to reset values and IDLE. Normal operation resumes on the next `frame_tick`.
